// File: rtl/switch_led_pkg.sv
// Shared definitions for the switch-driven 3-8 decoder LED demo.
//   mode_t        : operating mode of the scan sequencer
//   SW_OFF        : level of a DIP switch in the OFF position
//   KEY_RELEASED  : level of the mode key when not pressed
//   EN_BIT/DIR_BIT/RUN_BIT : field positions inside the 4-bit switch word
package switch_led_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_t;

  localparam logic SW_OFF       = 1'b1;
  localparam logic KEY_RELEASED = 1'b1;

  localparam int unsigned EN_BIT  = 3;
  localparam int unsigned DIR_BIT = 0;
  localparam int unsigned RUN_BIT = 1;

endpackage

// File: rtl/sw_debounce.sv
// One-bit 2-flop synchroniser followed by a stability-counter debouncer.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset (output returns to the OFF/released level)
//   din  : raw asynchronous input
//   dout : debounced, synchronous copy of din
module sw_debounce
  import switch_led_pkg::*;
#(
  parameter int unsigned DEB_CNT = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Accept a new level only after it has been seen for DEB_CNT consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= SW_OFF;
      sync2  <= SW_OFF;
      stable <= SW_OFF;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != stable) begin
        if (cnt == CNT_W'(DEB_CNT - 1)) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign dout = stable;

endmodule

// File: rtl/switch_scan_sequencer.sv
// Front stage of the 3-8 decoder LED demo: debounces the DIP switches and the
// mode key, then drives the decoder either straight from the switches (MANUAL)
// or from a free-running select counter (AUTO running light).
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   sw_raw     : raw DIP switches {en, sel[2:0]}, ON = 0
//   key_mode_n : raw mode push-button, pressed = 0
//   dec_in     : registered {en, sel[2:0]} to the decoder
//   auto_mode  : 1 while in AUTO
//   step_pulse : one-cycle pulse on every AUTO select advance
module switch_scan_sequencer
  import switch_led_pkg::*;
#(
  parameter int unsigned DEB_CNT  = 500_000,
  parameter int unsigned STEP_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_raw,
  input  logic       key_mode_n,
  output logic [3:0] dec_in,
  output logic       auto_mode,
  output logic       step_pulse
);

  localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [3:0]       sw_db;
  logic             key_db;
  logic             key_prev;
  logic             press;

  mode_t            mode, mode_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;
  logic [2:0]       scan_sel, sel_nx;
  logic [3:0]       dec_nx;
  logic             pulse_nx;
  logic             advance;
  logic             term;

  // Debounced copies of the four switches and the key.
  for (genvar i = 0; i < 4; i++) begin : g_sw_db
    sw_debounce #(.DEB_CNT(DEB_CNT)) u_sw_db (
      .clk  (clk),
      .rst  (rst),
      .din  (sw_raw[i]),
      .dout (sw_db[i])
    );
  end

  sw_debounce #(.DEB_CNT(DEB_CNT)) u_key_db (
    .clk  (clk),
    .rst  (rst),
    .din  (key_mode_n),
    .dout (key_db)
  );

  // Press = falling edge of the debounced active-low key.
  assign press   = key_prev & ~key_db;
  assign advance = sw_db[EN_BIT] & sw_db[RUN_BIT];
  assign term    = advance && (div_cnt == DIV_W'(STEP_DIV - 1));

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode       <= MODE_MANUAL;
      key_prev   <= KEY_RELEASED;
      div_cnt    <= '0;
      scan_sel   <= '0;
      dec_in     <= '0;
      step_pulse <= 1'b0;
    end else begin
      mode       <= mode_nx;
      key_prev   <= key_db;
      div_cnt    <= div_nx;
      scan_sel   <= sel_nx;
      dec_in     <= dec_nx;
      step_pulse <= pulse_nx;
    end
  end

  // Mode FSM, step divider and scan counter; a key press overrides a coincident step.
  always_comb begin
    mode_nx  = mode;
    div_nx   = div_cnt;
    sel_nx   = scan_sel;
    pulse_nx = 1'b0;
    dec_nx   = sw_db;
    case (mode)
      MODE_MANUAL: begin
        dec_nx = sw_db;
        if (press) begin
          mode_nx = MODE_AUTO;
          sel_nx  = sw_db[2:0];
          div_nx  = '0;
        end
      end
      MODE_AUTO: begin
        dec_nx = {sw_db[EN_BIT], scan_sel};
        if (press) begin
          mode_nx = MODE_MANUAL;
          div_nx  = '0;
        end else if (term) begin
          div_nx   = '0;
          pulse_nx = 1'b1;
          sel_nx   = sw_db[DIR_BIT] ? (scan_sel + 3'd1) : (scan_sel - 3'd1);
        end else if (advance) begin
          div_nx = div_cnt + DIV_W'(1);
        end
      end
      default: mode_nx = MODE_MANUAL;
    endcase
  end

  assign auto_mode = (mode == MODE_AUTO);

endmodule

// File: tb/tb_switch_scan_sequencer.sv
// Directed bench for switch_scan_sequencer with DEB_CNT = 4, STEP_DIV = 3.
// Inputs are driven and outputs sampled 1 ns after the rising edge; edge numbers
// in the comments count rising edges from the start of each directed step.
module tb_switch_scan_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] sw_raw;
  logic       key_mode_n;
  logic [3:0] dec_in;
  logic       auto_mode;
  logic       step_pulse;

  int checks = 0;
  int errors = 0;

  switch_scan_sequencer #(.DEB_CNT(4), .STEP_DIV(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .key_mode_n (key_mode_n),
    .dec_in     (dec_in),
    .auto_mode  (auto_mode),
    .step_pulse (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    sw_raw     = 4'b1111;
    key_mode_n = 1'b1;

    // 1. reset state and release
    tick(3);
    check("rst_dec", dec_in, 4'b0000);
    check("rst_auto", {3'b0, auto_mode}, 4'b0000);
    check("rst_pulse", {3'b0, step_pulse}, 4'b0000);
    rst = 1'b0;
    tick(2);
    check("release_dec", dec_in, 4'b1111);

    // 2. short glitch rejected, long change accepted after 2+DEB_CNT+1 edges
    sw_raw = 4'b1101;
    tick(3);
    sw_raw = 4'b1111;
    tick(8);
    check("glitch_rejected", dec_in, 4'b1111);
    sw_raw = 4'b1101;
    tick(6);
    check("deb_not_yet", dec_in, 4'b1111);
    tick(1);
    check("deb_accepted", dec_in, 4'b1101);
    tick(5);
    check("deb_holds", dec_in, 4'b1101);

    // 3. manual pass-through
    sw_raw = 4'b1010;
    tick(6);
    check("man_not_yet", dec_in, 4'b1101);
    tick(1);
    check("man_1010", dec_in, 4'b1010);
    check("man_pulse", {3'b0, step_pulse}, 4'b0000);
    check("man_mode", {3'b0, auto_mode}, 4'b0000);

    // 4. enter AUTO from sel 7, counting up
    sw_raw = 4'b1111;
    tick(8);
    key_mode_n = 1'b0;                 // edge 0
    tick(6);
    check("press_not_yet", {3'b0, auto_mode}, 4'b0000);
    tick(1);                           // edge 7: toggle
    check("auto_on", {3'b0, auto_mode}, 4'b0001);
    check("auto_dec", dec_in, 4'b1111);
    check("auto_pulse0", {3'b0, step_pulse}, 4'b0000);
    tick(1);                           // edge 8
    key_mode_n = 1'b1;
    tick(2);                           // edge 10: first step 7->0
    check("step1_pulse", {3'b0, step_pulse}, 4'b0001);
    check("step1_dec_old", dec_in, 4'b1111);
    tick(1);                           // edge 11
    check("step1_pulse_off", {3'b0, step_pulse}, 4'b0000);
    check("sel0", dec_in, 4'b1000);
    tick(2);                           // edge 13
    check("step2_pulse", {3'b0, step_pulse}, 4'b0001);
    tick(1);                           // edge 14
    check("sel1", dec_in, 4'b1001);
    tick(2);                           // edge 16
    check("step3_pulse", {3'b0, step_pulse}, 4'b0001);
    tick(1);                           // edge 17
    check("sel2", dec_in, 4'b1010);

    // 5. direction down (takes effect at edge 23), steps 3,4 up then 3..6 down
    sw_raw = 4'b1110;
    tick(8);                           // edge 25
    check("down_pulse", {3'b0, step_pulse}, 4'b0001);
    tick(1);                           // edge 26
    check("down_sel3", dec_in, 4'b1011);
    tick(5);                           // edge 31
    check("down_pulse2", {3'b0, step_pulse}, 4'b0001);
    tick(1);                           // edge 32
    check("down_sel1", dec_in, 4'b1001);
    tick(3);                           // edge 35
    check("down_sel0", dec_in, 4'b1000);
    tick(3);                           // edge 38
    check("down_wrap7", dec_in, 4'b1111);
    tick(3);                           // edge 41
    check("down_sel6", dec_in, 4'b1110);

    // hold: run bit falls at edge 47, sel frozen at 4 with div_cnt = 1
    sw_raw = 4'b1100;
    tick(7);                           // edge 48
    check("hold_sel4", dec_in, 4'b1100);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("hold_no_pulse", {3'b0, step_pulse}, 4'b0000);
      check("hold_dec", dec_in, 4'b1100);
    end
    // disable: en falls at edge 60 (relative to edge 54 = now)
    sw_raw = 4'b0100;
    tick(6);
    check("dis_not_yet", dec_in, 4'b1100);
    tick(1);
    check("dis_en0", dec_in, 4'b0100);
    // re-enable running down; frozen div_cnt = 1 gives a step on the second advancing cycle
    sw_raw = 4'b1110;
    tick(7);                           // edge 68
    check("resume_no_pulse", {3'b0, step_pulse}, 4'b0000);
    tick(1);                           // edge 69
    check("resume_pulse", {3'b0, step_pulse}, 4'b0001);
    tick(1);                           // edge 70
    check("resume_sel3", dec_in, 4'b1011);

    // 6. press lands on a terminal count (edge 78)
    tick(1);                           // edge 71
    key_mode_n = 1'b0;
    tick(6);                           // edge 77
    check("pre_toggle_auto", {3'b0, auto_mode}, 4'b0001);
    check("pre_toggle_pulse", {3'b0, step_pulse}, 4'b0000);
    tick(1);                           // edge 78
    check("toggle_manual", {3'b0, auto_mode}, 4'b0000);
    check("toggle_no_pulse", {3'b0, step_pulse}, 4'b0000);
    check("toggle_dec_last_auto", dec_in, 4'b1001);
    tick(1);                           // edge 79
    check("manual_dec", dec_in, 4'b1110);
    key_mode_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("manual_no_pulse", {3'b0, step_pulse}, 4'b0000);
    end

    // re-enter AUTO (edge 92), then async reset right after a step
    tick(1);                           // edge 85
    key_mode_n = 1'b0;
    tick(7);                           // edge 92
    check("reenter_auto", {3'b0, auto_mode}, 4'b0001);
    tick(1);                           // edge 93
    key_mode_n = 1'b1;
    tick(2);                           // edge 95
    check("prerst_pulse", {3'b0, step_pulse}, 4'b0001);
    rst = 1'b1;
    #1;
    check("async_rst_dec", dec_in, 4'b0000);
    check("async_rst_auto", {3'b0, auto_mode}, 4'b0000);
    check("async_rst_pulse", {3'b0, step_pulse}, 4'b0000);
    tick(2);
    check("rst_held_dec", dec_in, 4'b0000);
    rst = 1'b0;
    tick(2);
    check("post_rst_dec", dec_in, 4'b1111);
    check("post_rst_mode", {3'b0, auto_mode}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
